wb_forward_pipe: RTL and testbench

- Producer side of the ID-stage RAW forwarding interface.
- Carries each retiring result (we, waddr, wdata) from EX through the MEM and WB pipeline registers, and drives the register-file write port.
- Publishes the EX, MEM and WB forwarding triples that the ID hazard logic consumes.
- Owns the load handshake with data memory, load data extension, and the MEM-stage stall when load data is late.

---
 rtl/wb_forward_pipe.sv | 116 +++++++++++
 tb/tb_wb_forward_pipe.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_forward_pipe.sv
// EX->MEM->WB result pipeline feeding the ID-stage RAW forwarding network.
// Handles the data-memory load handshake, load extension and MEM stall.
module wb_forward_pipe #(
  parameter int RF_AW = 5,
  parameter int DW    = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             ex_valid_i,
  input  logic             ex_we_i,
  input  logic [RF_AW-1:0] ex_waddr_i,
  input  logic [DW-1:0]    ex_wdata_i,
  input  logic             ex_load_i,
  input  logic [1:0]       ex_load_size_i,
  input  logic             ex_load_unsigned_i,
  input  logic             flush_i,
  input  logic             mem_rvalid_i,
  input  logic [DW-1:0]    mem_rdata_i,
  output logic             mem_req_o,
  output logic [DW-1:0]    mem_addr_o,
  output logic             ex_fwd_we_o,
  output logic [RF_AW-1:0] ex_fwd_waddr_o,
  output logic [DW-1:0]    ex_fwd_wdata_o,
  output logic             mem_we_o,
  output logic [RF_AW-1:0] mem_waddr_o,
  output logic [DW-1:0]    mem_wdata_o,
  output logic             wb_we_o,
  output logic [RF_AW-1:0] wb_waddr_o,
  output logic [DW-1:0]    wb_wdata_o,
  output logic             mem_pending_o,
  output logic [RF_AW-1:0] mem_pending_waddr_o,
  output logic             stall_o
);

  typedef enum logic {M_IDLE, M_WAIT} mstate_t;

  mstate_t          state;
  logic             m_valid;
  logic             m_we;
  logic [RF_AW-1:0] m_waddr;
  logic [DW-1:0]    m_wdata;
  logic             m_load;
  logic [1:0]       m_size;
  logic             m_uns;

  logic             cap;
  logic             wb_we_n;
  logic [DW-1:0]    ld_data;
  logic [7:0]       ld_b;
  logic [15:0]      ld_h;

  assign cap = ex_valid_i & ~flush_i;

  assign ex_fwd_we_o = ~rst_i & cap & ex_we_i & ~ex_load_i
                     & (ex_waddr_i != '0);
  assign ex_fwd_waddr_o = rst_i ? '0 : ex_waddr_i;
  assign ex_fwd_wdata_o = rst_i ? '0 : ex_wdata_i;

  assign mem_req_o = (state == M_WAIT);
  assign mem_addr_o = mem_req_o ? {m_wdata[DW-1:2], 2'b00} : '0;
  assign stall_o = mem_req_o & ~mem_rvalid_i;

  assign mem_we_o = m_valid & m_we & ~m_load & (m_waddr != '0);
  assign mem_waddr_o = m_waddr;
  assign mem_wdata_o = m_wdata;
  assign mem_pending_o = mem_req_o;
  assign mem_pending_waddr_o = (mem_req_o & m_we) ? m_waddr : '0;

  // Little-endian lane select from the captured byte address
  assign ld_b = mem_rdata_i[{m_wdata[1:0], 3'b000} +: 8];
  assign ld_h = mem_rdata_i[{m_wdata[1], 4'b0000} +: 16];

  always_comb begin
    ld_data = mem_rdata_i;
    unique case (m_size)
      2'b00:   ld_data = {{(DW-8){~m_uns & ld_b[7]}}, ld_b};
      2'b01:   ld_data = {{(DW-16){~m_uns & ld_h[15]}}, ld_h};
      default: ld_data = mem_rdata_i;
    endcase
  end

  assign wb_we_n = m_valid & m_we & (m_waddr != '0)
                 & (~m_load | (mem_req_o & mem_rvalid_i));

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state      <= M_IDLE;
      m_valid    <= 1'b0;
      m_we       <= 1'b0;
      m_waddr    <= '0;
      m_wdata    <= '0;
      m_load     <= 1'b0;
      m_size     <= 2'b00;
      m_uns      <= 1'b0;
      wb_we_o    <= 1'b0;
      wb_waddr_o <= '0;
      wb_wdata_o <= '0;
    end else begin
      // A stalled MEM keeps its load; EX is not sampled
      if (!stall_o) begin
        m_valid <= cap;
        m_we    <= cap & ex_we_i;
        m_waddr <= cap ? ex_waddr_i : '0;
        m_wdata <= cap ? ex_wdata_i : '0;
        m_load  <= cap & ex_load_i;
        m_size  <= cap ? ex_load_size_i : 2'b00;
        m_uns   <= cap & ex_load_unsigned_i;
        state   <= (cap & ex_load_i) ? M_WAIT : M_IDLE;
      end
      wb_we_o    <= wb_we_n;
      wb_waddr_o <= m_waddr;
      wb_wdata_o <= m_load ? ld_data : m_wdata;
    end
  end

endmodule

// File: tb/tb_wb_forward_pipe.sv
// Directed bench for wb_forward_pipe; WB writes are checked by a
// scoreboard monitor against expected writes queued at issue time.
module tb_wb_forward_pipe;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        ex_valid_i, ex_we_i, ex_load_i, ex_load_unsigned_i;
  logic [4:0]  ex_waddr_i;
  logic [31:0] ex_wdata_i;
  logic [1:0]  ex_load_size_i;
  logic        flush_i, mem_rvalid_i;
  logic [31:0] mem_rdata_i;
  logic        mem_req_o;
  logic [31:0] mem_addr_o;
  logic        ex_fwd_we_o, mem_we_o, wb_we_o;
  logic [4:0]  ex_fwd_waddr_o, mem_waddr_o, wb_waddr_o;
  logic [31:0] ex_fwd_wdata_o, mem_wdata_o, wb_wdata_o;
  logic        mem_pending_o, stall_o;
  logic [4:0]  mem_pending_waddr_o;

  wb_forward_pipe dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .ex_valid_i(ex_valid_i), .ex_we_i(ex_we_i),
    .ex_waddr_i(ex_waddr_i), .ex_wdata_i(ex_wdata_i),
    .ex_load_i(ex_load_i), .ex_load_size_i(ex_load_size_i),
    .ex_load_unsigned_i(ex_load_unsigned_i), .flush_i(flush_i),
    .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i),
    .mem_req_o(mem_req_o), .mem_addr_o(mem_addr_o),
    .ex_fwd_we_o(ex_fwd_we_o), .ex_fwd_waddr_o(ex_fwd_waddr_o),
    .ex_fwd_wdata_o(ex_fwd_wdata_o),
    .mem_we_o(mem_we_o), .mem_waddr_o(mem_waddr_o),
    .mem_wdata_o(mem_wdata_o),
    .wb_we_o(wb_we_o), .wb_waddr_o(wb_waddr_o), .wb_wdata_o(wb_wdata_o),
    .mem_pending_o(mem_pending_o),
    .mem_pending_waddr_o(mem_pending_waddr_o),
    .stall_o(stall_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [4:0]  a;
    logic [31:0] d;
    int          c;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;
  int   n_vec = 0;
  int   n_err = 0;
  int   cyc = 0;

  always @(posedge clk_i) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic push(input logic [4:0] a, input logic [31:0] d,
                      input int c);
    exp_t e;
    e.a = a;
    e.d = d;
    e.c = c;
    q.push_back(e);
  endtask

  always @(negedge clk_i) begin
    if (!rst_i && wb_we_o) begin
      if (q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL wb_unexpected: got write x%0d=%h cyc %0d, want none",
                 wb_waddr_o, wb_wdata_o, cyc);
      end else begin
        mon_e = q.pop_front();
        chk("wb_waddr", 32'(wb_waddr_o), 32'(mon_e.a));
        chk("wb_wdata", wb_wdata_o, mon_e.d);
        chk("wb_cycle", cyc, mon_e.c);
      end
    end
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic samp();
    @(negedge clk_i);
  endtask

  task automatic idle_ex();
    ex_valid_i = 0; ex_we_i = 0; ex_waddr_i = 0; ex_wdata_i = 0;
    ex_load_i = 0; ex_load_size_i = 0; ex_load_unsigned_i = 0;
    flush_i = 0;
  endtask

  task automatic drive_alu(input logic [4:0] a, input logic [31:0] d);
    idle_ex();
    ex_valid_i = 1; ex_we_i = 1; ex_waddr_i = a; ex_wdata_i = d;
  endtask

  task automatic drive_load(input logic [4:0] a, input logic [31:0] ad,
                            input logic [1:0] sz, input logic u);
    idle_ex();
    ex_valid_i = 1; ex_we_i = 1; ex_waddr_i = a; ex_wdata_i = ad;
    ex_load_i = 1; ex_load_size_i = sz; ex_load_unsigned_i = u;
  endtask

  initial begin
    rst_i = 1;
    idle_ex();
    mem_rvalid_i = 0;
    mem_rdata_i = 0;
    drive_alu(5'd5, 32'h1234);
    repeat (2) samp();
    chk("rst_ex_fwd_we", 32'(ex_fwd_we_o), 0);
    chk("rst_ex_fwd_waddr", 32'(ex_fwd_waddr_o), 0);
    chk("rst_ex_fwd_wdata", ex_fwd_wdata_o, 0);
    chk("rst_mem_req", 32'(mem_req_o), 0);
    chk("rst_stall", 32'(stall_o), 0);
    chk("rst_mem_we", 32'(mem_we_o), 0);
    chk("rst_wb_we", 32'(wb_we_o), 0);
    tick();
    rst_i = 0;
    idle_ex();
    tick();

    // ALU forward through all three stages
    drive_alu(5'd5, 32'h1234);
    push(5'd5, 32'h1234, cyc + 2);
    samp();
    chk("alu_ex_we", 32'(ex_fwd_we_o), 1);
    chk("alu_ex_wdata", ex_fwd_wdata_o, 32'h1234);
    tick();
    idle_ex();
    samp();
    chk("alu_mem_we", 32'(mem_we_o), 1);
    chk("alu_mem_waddr", 32'(mem_waddr_o), 5);
    chk("alu_mem_wdata", mem_wdata_o, 32'h1234);
    tick();

    // x0 destination is never written
    drive_alu(5'd0, 32'hFFFF);
    samp();
    chk("x0_ex_we", 32'(ex_fwd_we_o), 0);
    tick();
    idle_ex();
    samp();
    chk("x0_mem_we", 32'(mem_we_o), 0);
    tick();

    // Zero-wait signed byte load
    drive_load(5'd10, 32'h103, 2'b00, 1'b0);
    push(5'd10, 32'hFFFFFF80, cyc + 2);
    samp();
    chk("lb_ex_we", 32'(ex_fwd_we_o), 0);
    tick();
    idle_ex();
    mem_rvalid_i = 1;
    mem_rdata_i = 32'h80112233;
    samp();
    chk("lb_req", 32'(mem_req_o), 1);
    chk("lb_addr", mem_addr_o, 32'h100);
    chk("lb_stall", 32'(stall_o), 0);
    chk("lb_pending", 32'(mem_pending_o), 1);
    chk("lb_pend_waddr", 32'(mem_pending_waddr_o), 10);
    chk("lb_mem_we", 32'(mem_we_o), 0);
    tick();
    mem_rvalid_i = 0;

    // Zero-wait unsigned byte load
    drive_load(5'd11, 32'h103, 2'b00, 1'b1);
    push(5'd11, 32'h00000080, cyc + 2);
    tick();
    idle_ex();
    mem_rvalid_i = 1;
    mem_rdata_i = 32'h80112233;
    samp();
    chk("lbu_stall", 32'(stall_o), 0);
    tick();
    mem_rvalid_i = 0;
    tick();

    // Slow half load: rvalid in the third wait cycle
    drive_load(5'd12, 32'h102, 2'b01, 1'b0);
    push(5'd12, 32'hFFFFBEEF, cyc + 4);
    tick();
    drive_alu(5'd13, 32'h55);
    samp();
    chk("lh_w1_stall", 32'(stall_o), 1);
    chk("lh_w1_pending", 32'(mem_pending_o), 1);
    chk("lh_w1_pend_waddr", 32'(mem_pending_waddr_o), 12);
    chk("lh_w1_addr", mem_addr_o, 32'h100);
    tick();
    flush_i = 1;
    samp();
    chk("lh_w2_stall", 32'(stall_o), 1);
    chk("lh_w2_ex_we", 32'(ex_fwd_we_o), 0);
    tick();
    flush_i = 0;
    mem_rvalid_i = 1;
    mem_rdata_i = 32'hBEEF0000;
    push(5'd13, 32'h55, cyc + 2);
    samp();
    chk("lh_w3_stall", 32'(stall_o), 0);
    chk("lh_w3_mem_we", 32'(mem_we_o), 0);
    tick();
    idle_ex();
    mem_rvalid_i = 0;
    samp();
    chk("lh_next_mem_we", 32'(mem_we_o), 1);
    chk("lh_next_mem_waddr", 32'(mem_waddr_o), 13);
    chk("lh_next_pending", 32'(mem_pending_o), 0);
    chk("lh_next_stall", 32'(stall_o), 0);
    tick();

    // Flushed instruction never writes
    drive_alu(5'd7, 32'h77);
    flush_i = 1;
    samp();
    chk("flush_ex_we", 32'(ex_fwd_we_o), 0);
    tick();
    idle_ex();
    samp();
    chk("flush_mem_we", 32'(mem_we_o), 0);
    tick();

    // rvalid while idle is ignored
    mem_rvalid_i = 1;
    mem_rdata_i = 32'h12345678;
    samp();
    chk("idle_rv_req", 32'(mem_req_o), 0);
    chk("idle_rv_stall", 32'(stall_o), 0);
    tick();
    mem_rvalid_i = 0;

    // Reset during an outstanding load abandons it
    drive_load(5'd14, 32'h200, 2'b10, 1'b0);
    tick();
    idle_ex();
    samp();
    chk("rml_req_before", 32'(mem_req_o), 1);
    #2 rst_i = 1;
    #1;
    chk("rml_req", 32'(mem_req_o), 0);
    chk("rml_stall", 32'(stall_o), 0);
    chk("rml_pending", 32'(mem_pending_o), 0);
    chk("rml_pend_waddr", 32'(mem_pending_waddr_o), 0);
    tick();
    rst_i = 0;
    mem_rvalid_i = 1;
    mem_rdata_i = 32'hFFFFFFFF;
    tick();
    mem_rvalid_i = 0;
    repeat (3) tick();
    samp();
    chk("rml_req_after", 32'(mem_req_o), 0);
    chk("sb_empty", q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
